// File: rtl/chg_rec_pkg.sv
// chg_rec_pkg
// Shared definitions for the value-change recorder.
//   DROP_CNT_W : width of the optional dropped-record counter
//   rec_t      : {ts, value} record at the default shape (TS_W=16, WIDTH=1);
//                the top declares the same layout from its own parameters
//   lvl_w()    : width of an occupancy counter able to hold 0..depth
//   rec_w()    : packed width of one {ts, value} record
package chg_rec_pkg;

  localparam int DROP_CNT_W = 8;
  localparam int DEF_WIDTH  = 1;
  localparam int DEF_TS_W   = 16;

  typedef struct packed {
    logic [DEF_TS_W-1:0]  ts;
    logic [DEF_WIDTH-1:0] value;
  } rec_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int rec_w(input int ts_w, input int width);
    return ts_w + width;
  endfunction

endpackage

// File: rtl/chg_rec_fifo.sv
// chg_rec_fifo
// Synchronous show-ahead FIFO holding change records.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full unless a pop happens the same cycle)
//   wdata    : record to store
//   pop      : discard the head entry (ignored when empty)
//   rdata    : head entry, zero while empty
//   full     : level == DEPTH
//   empty    : level == 0
//   level    : occupancy 0..DEPTH
module chg_rec_fifo
  import chg_rec_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DW-1:0]           wdata,
  input  logic                    pop,
  output logic [DW-1:0]           rdata,
  output logic                    full,
  output logic                    empty,
  output logic [lvl_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A full FIFO can still accept a write when the head leaves in the same
  // cycle; the write lands in the slot the head is vacating.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is masked to zero while empty so the storage itself needs no reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/chg_recorder.sv
// chg_recorder
// Value-change recorder: samples sig_in on every enabled cycle and queues a
// {timestamp, value} record whenever it differs from the last sample (the
// first enabled sample after reset is always recorded). Records drain through
// a valid/ready port.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : sampling / timestamp enable
//   sig_in    : monitored signal
//   rec_valid : head record available
//   rec_ready : sink accepts head record
//   rec_ts    : timestamp of head record
//   rec_value : value of head record
//   overflow  : sticky, at least one record dropped
//   level     : FIFO occupancy
//   drop_cnt  : saturating count of dropped records
//               (only when CHG_REC_DROP_CNT_EN is defined)
module chg_recorder
  import chg_rec_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WIDTH-1:0]        sig_in,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [TS_W-1:0]         rec_ts,
  output logic [WIDTH-1:0]        rec_value,
  output logic                    overflow,
  output logic [lvl_w(DEPTH)-1:0] level
`ifdef CHG_REC_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`endif
);

  localparam int RW = rec_w(TS_W, WIDTH);

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] value;
  } entry_t;

  logic [TS_W-1:0]  ts;
  logic             primed;
  logic [WIDTH-1:0] prev;
  logic             push_req;
  logic             drop;
  logic             full;
  logic             empty;
  entry_t           wr_entry;
  entry_t           head;
  logic [RW-1:0]    head_bits;

  // Record on the first enabled sample, then on every difference from the
  // previously sampled value. Changes while disabled collapse into one record.
  assign push_req = en && (!primed || (sig_in != prev));
  assign wr_entry = '{ts: ts, value: sig_in};

  // A full FIFO only loses the record when the sink is not popping this cycle.
  assign drop = push_req && full && !rec_ready;

  chg_rec_fifo #(
    .DEPTH (DEPTH),
    .DW    (RW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (wr_entry),
    .pop   (rec_ready),
    .rdata (head_bits),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign head      = entry_t'(head_bits);
  assign rec_valid = !empty;
  assign rec_ts    = head.ts;
  assign rec_value = head.value;

  // Sampling state: timestamp, primed flag and last sampled value all freeze
  // while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts     <= '0;
      primed <= 1'b0;
      prev   <= '0;
    end else if (en) begin
      ts     <= ts + TS_W'(1);
      primed <= 1'b1;
      prev   <= sig_in;
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef CHG_REC_DROP_CNT_EN
  // Dropped-record counter, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_chg_recorder.sv
// tb_chg_recorder
// Self-checking bench for chg_recorder. A queue-based model follows the
// recorder's rules (record on first enabled sample or on change, drop when
// full and not popping) and is compared against the DUT after every edge.
// A second instance with TS_W=4 covers timestamp wrap.
module tb_chg_recorder;

  localparam int WIDTH = 1;
  localparam int TS_W  = 16;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef CHG_REC_DROP_CNT_EN
  localparam int VW = 1 + TS_W + WIDTH + LW + 1 + 8;
`else
  localparam int VW = 1 + TS_W + WIDTH + LW + 1;
`endif

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] value;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] sig_in = '0;
  logic             rec_ready = 1'b0;
  logic             rec_valid;
  logic [TS_W-1:0]  rec_ts;
  logic [WIDTH-1:0] rec_value;
  logic             overflow;
  logic [LW-1:0]    level;
`ifdef CHG_REC_DROP_CNT_EN
  logic [7:0]       drop_cnt;
  logic [7:0]       drop_cnt2;
`endif

  logic             rst2 = 1'b1;
  logic             en2 = 1'b0;
  logic [WIDTH-1:0] sig2 = '0;
  logic             ready2 = 1'b0;
  logic             rec_valid2;
  logic [3:0]       rec_ts2;
  logic [WIDTH-1:0] rec_value2;
  logic             overflow2;
  logic [LW-1:0]    level2;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  rec_t             mq[$];
  logic [TS_W-1:0]  m_ts = '0;
  logic             m_primed = 1'b0;
  logic [WIDTH-1:0] m_prev = '0;
  logic             m_ovf = 1'b0;
  logic [7:0]       m_drop = '0;

  logic [VW-1:0] dut_vec;
`ifdef CHG_REC_DROP_CNT_EN
  assign dut_vec = {rec_valid, rec_ts, rec_value, level, overflow, drop_cnt};
`else
  assign dut_vec = {rec_valid, rec_ts, rec_value, level, overflow};
`endif

  always #5 clk = ~clk;

  chg_recorder #(.WIDTH(WIDTH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .rec_ts    (rec_ts),
    .rec_value (rec_value),
    .overflow  (overflow),
    .level     (level)
`ifdef CHG_REC_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  chg_recorder #(.WIDTH(WIDTH), .TS_W(4), .DEPTH(DEPTH)) dut2 (
    .clk       (clk),
    .rst       (rst2),
    .en        (en2),
    .sig_in    (sig2),
    .rec_valid (rec_valid2),
    .rec_ready (ready2),
    .rec_ts    (rec_ts2),
    .rec_value (rec_value2),
    .overflow  (overflow2),
    .level     (level2)
`ifdef CHG_REC_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt2)
`endif
  );

  // Expected outputs as seen from the model queue.
  function automatic logic [VW-1:0] model_vec();
    logic [TS_W-1:0]  ts = '0;
    logic [WIDTH-1:0] v = '0;
    logic             valid = (mq.size() != 0);
    if (valid) begin
      ts = mq[0].ts;
      v  = mq[0].value;
    end
`ifdef CHG_REC_DROP_CNT_EN
    return {valid, ts, v, LW'(mq.size()), m_ovf, m_drop};
`else
    return {valid, ts, v, LW'(mq.size()), m_ovf};
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ts     = '0;
    m_primed = 1'b0;
    m_prev   = '0;
    m_ovf    = 1'b0;
    m_drop   = '0;
  endtask

  // One clock: the model consumes the inputs present at the edge, then the
  // bench waits 1 time unit so outputs are sampled away from the edge.
  task automatic tick();
    logic do_pop;
    logic do_push;
    @(posedge clk);
    do_pop  = (mq.size() != 0) && rec_ready;
    do_push = en && (!m_primed || (sig_in != m_prev));
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) begin
        mq.push_back('{ts: m_ts, value: sig_in});
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
    end
    if (en) begin
      m_primed = 1'b1;
      m_prev   = sig_in;
      m_ts     = m_ts + TS_W'(1);
    end
    #1;
  endtask

  task automatic reset_all();
    rst       = 1'b1;
    en        = 1'b0;
    sig_in    = '0;
    rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected 0", dut_vec);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_initial_dump();
    reset_all();
    en = 1'b1;
    sig_in = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL dump_cycle%0d: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    checks++;
    if (level !== LW'(1) || rec_ts !== '0 || rec_value !== '0) begin
      errors++;
      $display("[TB] FAIL dump_record: got level=%0d ts=%0d v=%0d expected level=1 ts=0 v=0",
               level, rec_ts, rec_value);
    end
    rec_ready = 1'b1;
    tick();
    checks++;
    if (level !== '0 || rec_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dump_drain: got level=%0d valid=%b expected 0 0", level, rec_valid);
    end
  endtask

  task automatic test_sequence();
    reset_all();
    en = 1'b1;
    rec_ready = 1'b1;
    for (int t = 0; t < 25; t++) begin
      sig_in = WIDTH'((t >= 10 && t < 20) ? 1 : 0);
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL seq_t%0d: got %h expected %h", t, dut_vec, model_vec());
      end
      if (t == 0 || t == 10 || t == 20) begin
        checks++;
        if (rec_valid !== 1'b1 || rec_ts !== TS_W'(t) || rec_value !== WIDTH'(t == 10)) begin
          errors++;
          $display("[TB] FAIL seq_record_t%0d: got valid=%b ts=%0d v=%0d expected valid=1 ts=%0d v=%0d",
                   t, rec_valid, rec_ts, rec_value, t, (t == 10));
        end
      end
    end
  endtask

  task automatic test_overflow();
    reset_all();
    en = 1'b1;
    for (int t = 0; t < 10; t++) begin
      sig_in = WIDTH'(t & 1);
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL ovf_t%0d: got %h expected %h", t, dut_vec, model_vec());
      end
    end
    checks++;
    if (level !== LW'(8) || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_state: got level=%0d ovf=%b expected 8 1", level, overflow);
    end
`ifdef CHG_REC_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd2) begin
      errors++;
      $display("[TB] FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt);
    end
`endif
    en = 1'b0;
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rec_valid !== 1'b1 || rec_ts !== TS_W'(i)) begin
        errors++;
        $display("[TB] FAIL ovf_drain%0d: got valid=%b ts=%0d expected 1 %0d", i, rec_valid, rec_ts, i);
      end
      tick();
    end
    checks++;
    if (level !== '0 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovf_drained: got level=%0d ovf=%b expected 0 1", level, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    reset_all();
    en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      sig_in = WIDTH'(t & 1);
      tick();
    end
    checks++;
    if (level !== LW'(8) || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_fill: got level=%0d ovf=%b expected 8 0", level, overflow);
    end
    rec_ready = 1'b1;
    sig_in = ~sig_in;
    tick();
    checks++;
    if (level !== LW'(8) || overflow !== 1'b0 || rec_ts !== TS_W'(1)) begin
      errors++;
      $display("[TB] FAIL full_push_pop: got level=%0d ovf=%b ts=%0d expected 8 0 1",
               level, overflow, rec_ts);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++;
      $display("[TB] FAIL full_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_enable_gap();
    reset_all();
    rec_ready = 1'b1;
    for (int t = 0; t < 13; t++) begin
      en = !(t >= 5 && t <= 9);
      if (t < 5)       sig_in = '0;
      else if (t < 10) sig_in = WIDTH'((t - 5) & 1);
      else if (t < 12) sig_in = WIDTH'(1);
      else             sig_in = '0;
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL gap_t%0d: got %h expected %h", t, dut_vec, model_vec());
      end
      if (t == 10 || t == 12) begin
        checks++;
        if (rec_valid !== 1'b1 || rec_ts !== TS_W'(t - 5) || rec_value !== WIDTH'(t == 10)) begin
          errors++;
          $display("[TB] FAIL gap_record_t%0d: got valid=%b ts=%0d v=%0d expected 1 %0d %0d",
                   t, rec_valid, rec_ts, rec_value, t - 5, (t == 10));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    reset_all();
    en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      sig_in = WIDTH'(t & 1);
      tick();
    end
    checks++;
    if (level !== LW'(3)) begin
      errors++;
      $display("[TB] FAIL arst_queued: got level=%0d expected 3", level);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rec_valid !== 1'b0 || level !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arst_immediate: got valid=%b level=%0d ovf=%b expected 0 0 0",
               rec_valid, level, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sig_in = WIDTH'(1);
    tick();
    checks++;
    if (rec_valid !== 1'b1 || rec_ts !== '0 || rec_value !== WIDTH'(1)) begin
      errors++;
      $display("[TB] FAIL arst_redump: got valid=%b ts=%0d v=%0d expected 1 0 1",
               rec_valid, rec_ts, rec_value);
    end
  endtask

  task automatic test_random();
    reset_all();
    for (int t = 0; t < 400; t++) begin
      en        = ($urandom_range(0, 3) != 0);
      sig_in    = WIDTH'($urandom);
      rec_ready = (t < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("[TB] FAIL random_t%0d: got %h expected %h", t, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_ts_wrap();
    logic [3:0] exp_ts;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst2   = 1'b0;
    en2    = 1'b1;
    ready2 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      sig2 = WIDTH'(c >= 17);
      @(posedge clk);
      #1;
    end
    checks++;
    if (level2 !== LW'(2) || rec_ts2 !== 4'd0 || overflow2 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_queue: got level=%0d ts=%0d ovf=%b expected 2 0 0",
               level2, rec_ts2, overflow2);
    end
`ifdef CHG_REC_DROP_CNT_EN
    checks++;
    if (drop_cnt2 !== 8'd0) begin
      errors++;
      $display("[TB] FAIL wrap_drop_cnt: got %0d expected 0", drop_cnt2);
    end
`endif
    en2    = 1'b0;
    ready2 = 1'b1;
    @(posedge clk);
    #1;
    ready2 = 1'b0;
    exp_ts = 4'(17 % 16);
    checks++;
    if (rec_valid2 !== 1'b1 || rec_ts2 !== exp_ts || rec_value2 !== WIDTH'(1)) begin
      errors++;
      $display("[TB] FAIL wrap_ts: got valid=%b ts=%0d v=%0d expected 1 %0d 1",
               rec_valid2, rec_ts2, rec_value2, exp_ts);
    end
  endtask

  initial begin
    test_reset();
    test_initial_dump();
    test_sequence();
    test_overflow();
    test_full_push_pop();
    test_enable_gap();
    test_async_reset();
    test_random();
    test_ts_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
